// File: rtl/exception_sequencer.sv
// Exception entry controller: picks the cause, saves EPC and Cause, fetches
// the handler byte from 253..255 and loads it into the PC while stalling control.
module exception_sequencer #(
  parameter logic [31:0] PC_OFFSET   = 32'd4,
  parameter int          MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        invalid_opcode,
  input  logic        overflow,
  input  logic        div_by_zero,
  input  logic [31:0] pc_current,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  exception_cause_sel,
  output logic        cause_write,
  output logic        epc_write,
  output logic [31:0] epc_data,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        dropped_exception
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SAVE  = 2'b01,
    ST_FETCH = 2'b10,
    ST_JUMP  = 2'b11
  } state_t;

  localparam logic [3:0]  LAT_RELOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [31:0] HANDLER_BASE = 32'd253;

  // Fixed priority: invalid opcode, then overflow, then divide-by-zero.
  function automatic logic [1:0] pick_cause(input logic inv, input logic ovf);
    logic [1:0] sel;
    if (inv) begin
      sel = 2'b00;
    end else if (ovf) begin
      sel = 2'b01;
    end else begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        dropped_q, dropped_d;

  logic        busy_q, busy_d;
  logic        cause_write_q, cause_write_d;
  logic        epc_write_q, epc_write_d;
  logic [31:0] epc_data_q, epc_data_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        pc_write_q, pc_write_d;
  logic [31:0] pc_next_q, pc_next_d;

  logic        any_flag_s;
  logic        unused_rdata_s;

  assign any_flag_s     = invalid_opcode | overflow | div_by_zero;
  assign unused_rdata_s = ^mem_rdata[31:8];

  // Next-state logic: sequence progression, cause/EPC latching, drop tracking.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    dropped_d = dropped_q;
    case (state_q)
      ST_IDLE: begin
        if (any_flag_s) begin
          state_d = ST_SAVE;
          cause_d = pick_cause(invalid_opcode, overflow);
          epc_d   = pc_current - PC_OFFSET;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAVE: begin
        state_d = ST_FETCH;
        cnt_d   = LAT_RELOAD;
      end
      ST_FETCH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_JUMP;
          byte_d  = mem_rdata[7:0];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_JUMP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Any flag seen outside IDLE is lost; remember that it happened.
    if ((state_q != ST_IDLE) && any_flag_s) begin
      dropped_d = 1'b1;
    end else begin
      dropped_d = dropped_d;
    end
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    busy_d        = 1'b0;
    cause_write_d = 1'b0;
    epc_write_d   = 1'b0;
    epc_data_d    = 32'd0;
    mem_read_d    = 1'b0;
    mem_addr_d    = 32'd0;
    pc_write_d    = 1'b0;
    pc_next_d     = 32'd0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_SAVE: begin
        busy_d        = 1'b1;
        cause_write_d = 1'b1;
        epc_write_d   = 1'b1;
        epc_data_d    = epc_d;
        mem_addr_d    = HANDLER_BASE + {30'd0, cause_d};
      end
      ST_FETCH: begin
        busy_d     = 1'b1;
        mem_read_d = 1'b1;
        epc_data_d = epc_d;
        mem_addr_d = HANDLER_BASE + {30'd0, cause_d};
      end
      ST_JUMP: begin
        busy_d     = 1'b1;
        pc_write_d = 1'b1;
        epc_data_d = epc_d;
        mem_addr_d = HANDLER_BASE + {30'd0, cause_d};
        pc_next_d  = {24'd0, byte_d};
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, context and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cause_q       <= 2'b00;
      epc_q         <= 32'd0;
      cnt_q         <= 4'd0;
      byte_q        <= 8'd0;
      dropped_q     <= 1'b0;
      busy_q        <= 1'b0;
      cause_write_q <= 1'b0;
      epc_write_q   <= 1'b0;
      epc_data_q    <= 32'd0;
      mem_read_q    <= 1'b0;
      mem_addr_q    <= 32'd0;
      pc_write_q    <= 1'b0;
      pc_next_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      cnt_q         <= cnt_d;
      byte_q        <= byte_d;
      dropped_q     <= dropped_d;
      busy_q        <= busy_d;
      cause_write_q <= cause_write_d;
      epc_write_q   <= epc_write_d;
      epc_data_q    <= epc_data_d;
      mem_read_q    <= mem_read_d;
      mem_addr_q    <= mem_addr_d;
      pc_write_q    <= pc_write_d;
      pc_next_q     <= pc_next_d;
    end
  end

  assign busy                = busy_q;
  assign exception_cause_sel = cause_q;
  assign cause_write         = cause_write_q;
  assign epc_write           = epc_write_q;
  assign epc_data            = epc_data_q;
  assign mem_read            = mem_read_q;
  assign mem_addr            = mem_addr_q;
  assign pc_write            = pc_write_q;
  assign pc_next             = pc_next_q;
  assign dropped_exception   = dropped_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench: two instances (read latency 1 and 3) share stimulus and
// are checked against a cycle-level behavioural model of the entry sequence.
module tb_exception_sequencer;

  localparam int NCYC = 700;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] epc;
    logic [7:0]  byt;
  } tx_t;

  typedef struct {
    logic       busy;
    logic       dropped;
    logic       rst;
    logic [1:0] sel;
  } cy_t;

  logic        clk = 1'b0;
  logic        reset, invalid_opcode, overflow, div_by_zero;
  logic [31:0] pc_current, mem_rdata;

  logic        busy_w [2];
  logic [1:0]  sel_w [2];
  logic        cw_w [2], ew_w [2], mr_w [2], pw_w [2], drop_w [2];
  logic [31:0] epcd_w [2], addr_w [2], pcn_w [2];

  logic [31:0] rdata_tab [NCYC+32];
  tx_t         txq [2][$];
  cy_t         cyq [2][$];
  int          free_c [2];
  logic        m_drop [2];
  logic [1:0]  m_sel [2];
  tx_t         cur [2];
  logic        cur_act [2];
  int          rd_cnt [2];
  int          age [2];
  int          checks = 0;
  int          errors = 0;
  logic        done = 1'b0;

  always #5 clk = ~clk;

  exception_sequencer #(.PC_OFFSET(32'd4), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .invalid_opcode(invalid_opcode), .overflow(overflow),
    .div_by_zero(div_by_zero), .pc_current(pc_current), .mem_rdata(mem_rdata),
    .busy(busy_w[0]), .exception_cause_sel(sel_w[0]), .cause_write(cw_w[0]),
    .epc_write(ew_w[0]), .epc_data(epcd_w[0]), .mem_read(mr_w[0]), .mem_addr(addr_w[0]),
    .pc_write(pw_w[0]), .pc_next(pcn_w[0]), .dropped_exception(drop_w[0]));

  exception_sequencer #(.PC_OFFSET(32'd4), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .invalid_opcode(invalid_opcode), .overflow(overflow),
    .div_by_zero(div_by_zero), .pc_current(pc_current), .mem_rdata(mem_rdata),
    .busy(busy_w[1]), .exception_cause_sel(sel_w[1]), .cause_write(cw_w[1]),
    .epc_write(ew_w[1]), .epc_data(epcd_w[1]), .mem_read(mr_w[1]), .mem_addr(addr_w[1]),
    .pc_write(pw_w[1]), .pc_next(pcn_w[1]), .dropped_exception(drop_w[1]));

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat=%0d t=%0t actual=%h expected=%h", name, lat(k), $time, act, exp);
    end
  endtask

  // Inputs presented for edge number c.
  task automatic drive_inputs(input int c);
    reset          = (c < 2) || (c == 57);
    invalid_opcode = (c == 14) || (c == 34) || (c == 54);
    overflow       = (c == 4) || (c == 14) || (c == 47) || (c >= 62 && c <= 71);
    div_by_zero    = (c == 14) || (c == 24) || (c == 44);
    pc_current     = (c == 4) ? 32'h0000_0040 : (c == 34) ? 32'h0000_0002 : 32'h0000_1000 + c;
    if (c >= 80 && c < NCYC - 30) begin
      reset          = ($urandom_range(0, 89) == 0);
      invalid_opcode = ($urandom_range(0, 11) == 0);
      overflow       = ($urandom_range(0, 11) == 0);
      div_by_zero    = ($urandom_range(0, 11) == 0);
      pc_current     = $urandom;
    end
    mem_rdata = rdata_tab[c];
  endtask

  // Spec-level model: a trigger at edge s keeps the block busy for edges
  // s..s+L+1, captures memory at edge s+L+1 and is idle again at edge s+L+3.
  task automatic model_edge(input int k, input int c);
    cy_t e;
    tx_t t;
    logic any;
    any = invalid_opcode | overflow | div_by_zero;
    if (reset) begin
      free_c[k] = c + 1;
      m_drop[k] = 1'b0;
      m_sel[k]  = 2'b00;
      txq[k].delete();
    end else if (c < free_c[k]) begin
      if (any) m_drop[k] = 1'b1;
    end else if (any) begin
      t.sel = invalid_opcode ? 2'd0 : overflow ? 2'd1 : 2'd2;
      t.epc = pc_current - 32'd4;
      t.byt = rdata_tab[c + 1 + lat(k)][7:0];
      m_sel[k]  = t.sel;
      free_c[k] = c + lat(k) + 3;
      txq[k].push_back(t);
    end
    e.rst     = reset;
    e.busy    = !reset && (c < free_c[k] - 1);
    e.dropped = m_drop[k];
    e.sel     = m_sel[k];
    cyq[k].push_back(e);
  endtask

  task automatic monitor_step(input int k);
    cy_t e;
    if (cyq[k].size() == 0) return;
    e = cyq[k].pop_front();
    chk("busy", k, 32'(busy_w[k]), 32'(e.busy));
    chk("dropped", k, 32'(drop_w[k]), 32'(e.dropped));
    chk("sel_hold", k, 32'(sel_w[k]), 32'(e.sel));
    if (e.rst) cur_act[k] = 1'b0;
    if (!e.busy) begin
      chk("idle_strobes", k, {28'd0, cw_w[k], ew_w[k], mr_w[k], pw_w[k]}, 32'd0);
      chk("idle_data", k, epcd_w[k] | addr_w[k] | pcn_w[k], 32'd0);
    end
    if (cw_w[k]) begin
      if (cur_act[k] || txq[k].size() == 0) begin
        chk("unexpected_save", k, 32'd1, 32'd0);
      end else begin
        cur[k] = txq[k].pop_front();
        cur_act[k] = 1'b1;
        rd_cnt[k] = 0;
        age[k] = 0;
        chk("save_sel", k, 32'(sel_w[k]), 32'(cur[k].sel));
        chk("save_epc", k, epcd_w[k], cur[k].epc);
        chk("save_addr", k, addr_w[k], 32'd253 + 32'(cur[k].sel));
        chk("save_epcw", k, 32'(ew_w[k]), 32'd1);
      end
    end
    if (mr_w[k]) begin
      rd_cnt[k]++;
      chk("fetch_addr", k, addr_w[k], 32'd253 + 32'(cur[k].sel));
    end
    if (pw_w[k]) begin
      if (!cur_act[k]) begin
        chk("unexpected_jump", k, 32'd1, 32'd0);
      end else begin
        chk("jump_pc", k, pcn_w[k], {24'd0, cur[k].byt});
        chk("read_cycles", k, 32'(rd_cnt[k]), 32'(lat(k)));
        cur_act[k] = 1'b0;
      end
    end
    if (cur_act[k]) begin
      age[k]++;
      if (age[k] > lat(k) + 3) begin
        chk("sequence_timeout", k, 32'(age[k]), 32'(lat(k) + 2));
        cur_act[k] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NCYC + 32; i++) begin
      rdata_tab[i] = (i < 12) ? 32'h0000_0080 : (i < 40) ? 32'hFFFF_FF12 : $urandom;
    end
    for (int k = 0; k < 2; k++) begin
      free_c[k] = 0; m_drop[k] = 1'b0; m_sel[k] = 2'b00; cur_act[k] = 1'b0;
      rd_cnt[k] = 0; age[k] = 0;
    end
    drive_inputs(0);
    fork
      begin
        for (int c = 0; c < NCYC; c++) begin
          @(posedge clk);
          for (int k = 0; k < 2; k++) model_edge(k, c);
          #2;
          drive_inputs(c + 1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          for (int k = 0; k < 2; k++) monitor_step(k);
        end
      end
    join
    for (int k = 0; k < 2; k++) begin
      chk("pending_at_end", k, 32'(txq[k].size()) + 32'(cur_act[k]), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Multicycle-CPU exception entry controller, directly upstream of the exception-cause mux.
- Detects invalid-opcode, overflow and divide-by-zero events and drives the 2-bit cause select that feeds the mux (00→253, 01→254, 10→255).
- Sequences the entry: EPC save, Cause write, handler-byte fetch from memory address 253/254/255, PC load.
- Stalls the main control unit while busy.

Parameters:
- PC_OFFSET, 4, value subtracted from pc_current to form EPC (PC is already incremented when the flag fires).
- MEM_LATENCY, 1, cycles mem_read is held before mem_rdata is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- invalid_opcode  input  1  decode found an unknown opcode.
- overflow  input  1  ALU signed overflow on add/sub/addi.
- div_by_zero  input  1  divider divisor == 0.
- pc_current  input  32  current PC value.
- mem_rdata  input  32  memory read data; handler byte is bits [7:0].
- busy  output  1  high in every non-IDLE state; control unit freezes.
- exception_cause_sel  output  2  select to the cause mux.
- cause_write  output  1  Cause register write enable.
- epc_write  output  1  EPC register write enable.
- epc_data  output  32  EPC write value.
- mem_read  output  1  memory read request.
- mem_addr  output  32  memory byte address.
- pc_write  output  1  PC write enable.
- pc_next  output  32  new PC value.
- dropped_exception  output  1  sticky: a flag arrived while busy.

Behaviour:
- Reset (synchronous, active-high): state IDLE, all outputs 0, exception_cause_sel=2'b00, wait counter 0, dropped_exception cleared. Reset asserted mid-sequence aborts at that edge; no further pc_write, cause_write or epc_write.
- States: IDLE, SAVE, FETCH, JUMP. All outputs are registered or pure Moore decodes of registered state.
- IDLE: outputs 0 except exception_cause_sel, which holds its last value.
  - At an edge where any flag is high: latch the cause, latch epc = pc_current - PC_OFFSET (mod 2^32), go to SAVE.
  - Priority when several flags are high: invalid_opcode (sel 00) > overflow (01) > div_by_zero (10).
  - sel 11 is never produced.
- SAVE (1 cycle): busy=1, cause_write=1, epc_write=1, epc_data=latched EPC, sel=latched cause, mem_addr=253+sel. Next state FETCH, counter loaded with MEM_LATENCY-1.
- FETCH (MEM_LATENCY cycles): busy=1, mem_read=1, mem_addr=253+sel, cause_write=0, epc_write=0.
  - Counter decrements each cycle.
  - At the edge where the counter is 0: capture mem_rdata[7:0], go to JUMP.
- JUMP (1 cycle): busy=1, pc_write=1, pc_next={24'b0, captured byte}, mem_read=0. Next state IDLE.
- Total busy cycles = MEM_LATENCY + 2. Flags are not sampled again until IDLE.
- Any flag high at an edge in a non-IDLE state is discarded and sets dropped_exception=1; it stays set until reset.
- Outside SAVE..JUMP: mem_addr=0, epc_data=0, pc_next=0.
- A flag held continuously re-triggers on the first IDLE edge after JUMP (back-to-back sequences are legal, zero idle gap beyond one IDLE cycle).

Test Plan:
- overflow=1 for one cycle, pc_current=0x0000_0040, MEM_LATENCY=1, mem_rdata=0x0000_0080 → SAVE: sel=01, cause_write=1, epc_write=1, epc_data=0x3C, mem_addr=254; FETCH: mem_read=1 for 1 cycle; JUMP: pc_write=1, pc_next=0x80; busy high for exactly 3 cycles.
- invalid_opcode=1, overflow=1, div_by_zero=1 at the same edge → sel=00, mem_addr=253; with only div_by_zero=1 → sel=10, mem_addr=255.
- MEM_LATENCY=3, div_by_zero pulse, mem_rdata=0xFFFF_FF12 stable → mem_read high 3 cycles, pc_next=0x0000_0012, busy=5 cycles.
- pc_current=0x0000_0002 with invalid_opcode → epc_data=0xFFFF_FFFE (wrap).
- overflow pulse during FETCH → ignored, dropped_exception=1 and stays set; no second sequence starts.
- reset asserted during FETCH → next cycle state IDLE, all outputs 0, pc_write never asserted, dropped_exception=0.
